// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared fetch-state encoding, NOP word and opcode constants
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

endpackage

`default_nettype wire

// File: rtl/ifetch_stage_pc_next_sel.sv
// ============================================================================
// pc_next_sel : combinational next-PC / bubble / hold selection for fetch
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_sel
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  fetch_state_t      state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              bubble,
  output logic              hold,
  output logic              misalign
);

  logic unused_jump_bits;
  assign unused_jump_bits = ^jump_index[25:ADDR_W-2];

  always_comb begin
    pc_plus4 = pc + ADDR_W'(4);
    pc_next  = pc;
    bubble   = 1'b0;
    hold     = 1'b0;
    misalign = 1'b0;
    unique case (state)
      ST_RUN: begin
        // Branch is the older instruction, so it beats a same-cycle jump.
        if (branch_taken) begin
          pc_next  = {branch_target[ADDR_W-1:2], 2'b00};
          bubble   = 1'b1;
          misalign = |branch_target[1:0];
        end else if (jump) begin
          pc_next = {jump_index[ADDR_W-3:0], 2'b00};
          bubble  = 1'b1;
        end else if (flush) begin
          pc_next = stall ? pc : pc_plus4;
          bubble  = 1'b1;
        end else if (stall) begin
          hold = 1'b1;
        end else begin
          pc_next = pc_plus4;
        end
      end
      default: begin
        // BOOT and HALT both freeze the PC and feed bubbles downstream.
        bubble = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
// ============================================================================
// ifetch_stage : PC ownership, imem addressing and IF/ID register with
//                BOOT/RUN/HALT control. Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_stage #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = 8'h00,
  parameter logic [31:0]        NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              fetch_fault,
  output logic [1:0]        state
);

  import mips_pkg::*;

  fetch_state_t      cur_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus4;
  logic              bubble;
  logic              hold;
  logic              misalign;

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_sel (
    .state        (cur_state),
    .pc           (pc),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .pc_next      (pc_next),
    .pc_plus4     (pc_plus4),
    .bubble       (bubble),
    .hold         (hold),
    .misalign     (misalign)
  );

  assign imem_addr = pc;
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= ST_BOOT;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      fetch_fault <= 1'b0;
    end else begin
      pc <= pc_next;
      if (misalign) begin
        fetch_fault <= 1'b1;
      end

      if (bubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_WORD;
        if_id_pc4   <= '0;
      end else if (!hold) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem_data;
        if_id_pc4   <= pc_plus4;
      end

      unique case (cur_state)
        ST_BOOT: cur_state <= ST_RUN;
        ST_RUN:  if (halt_req) cur_state <= ST_HALT;
        ST_HALT: if (resume)   cur_state <= ST_RUN;
        default: cur_state <= ST_BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire
